// File: rtl/ika87ad_opdec_queue.sv
// Prefix-folding opcode decode stage feeding a QDEPTH-entry queue toward the microcode sequencer.
// Latency 1 cycle byte->o_Q_* (0 with IKA87AD_DECQ_BYPASS_EN defined); o_BYTE_READY = !full & !i_FLUSH.
module ika87ad_opdec_queue #(
  parameter int QDEPTH = 4,
  parameter int SA_W   = 8,
  parameter int PAGE_W = 3
) (
  input  logic                      i_EMUCLK,
  input  logic                      i_RESET,
  input  logic                      i_FLUSH,
  input  logic [7:0]                i_BYTE,
  input  logic                      i_BYTE_VALID,
  output logic                      o_BYTE_READY,
  output logic [7:0]                o_LUT_OP,
  output logic [PAGE_W-1:0]         o_LUT_PAGE,
  input  logic [SA_W-1:0]           i_LUT_SA,
  output logic                      o_Q_VALID,
  input  logic                      i_Q_READY,
  output logic [7:0]                o_Q_OP,
  output logic [PAGE_W-1:0]         o_Q_PAGE,
  output logic [SA_W-1:0]           o_Q_SA,
  output logic [1:0]                o_Q_LEN,
  output logic                      o_PFX_PEND,
  output logic [$clog2(QDEPTH):0]   o_Q_COUNT
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic { ST_OPC = 1'b0, ST_PFX = 1'b1 } state_t;

  typedef struct packed {
    logic [PAGE_W-1:0] page;
    logic [7:0]        op;
    logic [SA_W-1:0]   sa;
    logic [1:0]        len;
  } entry_t;

  function automatic logic [PAGE_W-1:0] pfx_page(input logic [7:0] b);
    case (b)
      8'h48:   return PAGE_W'(1);
      8'h60:   return PAGE_W'(2);
      8'h64:   return PAGE_W'(3);
      8'h70:   return PAGE_W'(4);
      8'h74:   return PAGE_W'(5);
      default: return '0;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [PAGE_W-1:0] page_q, page_d;
  entry_t            mem_q [QDEPTH];
  entry_t            mem_d [QDEPTH];
  entry_t            hold_q, hold_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              in_pfx, byte_is_pfx, byte_rdy, byte_acc;
  logic              push, wr, pop, bypass, q_nonempty, q_vld;
  logic [PAGE_W-1:0] byte_page;
  entry_t            new_ent, head;

  // FSM: state register
  always_ff @(posedge i_EMUCLK) begin
    if (i_RESET) begin
      state_q <= ST_OPC;
      page_q  <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    if (i_FLUSH) begin
      state_d = ST_OPC;
      page_d  = '0;
    end else if (byte_acc) begin
      case (state_q)
        ST_OPC: if (byte_is_pfx) begin
          state_d = ST_PFX;
          page_d  = byte_page;
        end
        ST_PFX: begin
          state_d = ST_OPC;
          page_d  = '0;
        end
        default: state_d = ST_OPC;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_pfx     = (state_q == ST_PFX);
    o_PFX_PEND = in_pfx;
    o_LUT_PAGE = in_pfx ? page_q : '0;
  end

  always_comb begin
    byte_page   = pfx_page(i_BYTE);
    byte_is_pfx = (byte_page != '0);
    q_nonempty  = (count_q != '0);
    byte_rdy    = (count_q != CW'(QDEPTH)) & ~i_FLUSH;
    byte_acc    = i_BYTE_VALID & byte_rdy;
    // In the PFX state the byte is always the opcode, even if it looks like a prefix.
    push        = byte_acc & (in_pfx | ~byte_is_pfx);
    new_ent     = '{page: o_LUT_PAGE, op: i_BYTE, sa: i_LUT_SA,
                    len: (in_pfx ? 2'd2 : 2'd1)};
`ifdef IKA87AD_DECQ_BYPASS_EN
    bypass      = push & ~q_nonempty & i_Q_READY & ~i_RESET;
`else
    bypass      = 1'b0;
`endif
    wr          = push & ~bypass;
    pop         = q_nonempty & i_Q_READY & ~i_FLUSH;
    q_vld       = q_nonempty | bypass;
    if (q_nonempty)  head = mem_q[rd_ptr_q];
    else if (bypass) head = new_ent;
    else             head = hold_q;
    // Keep the last presented entry so head fields stay stable while empty.
    hold_d      = q_vld ? head : hold_q;

    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = new_ent;

    if (i_FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(wr);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    mem_q <= mem_d;
  end

  assign o_BYTE_READY = byte_rdy;
  assign o_LUT_OP     = i_BYTE;
  assign o_Q_VALID    = q_vld;
  assign o_Q_OP       = head.op;
  assign o_Q_PAGE     = head.page;
  assign o_Q_SA       = head.sa;
  assign o_Q_LEN      = head.len;
  assign o_Q_COUNT    = count_q;

endmodule

// File: tb/tb_ika87ad_opdec_queue.sv
// Directed bench for ika87ad_opdec_queue; LUT stub returns SA = {page, op[4:0]}.
module tb_ika87ad_opdec_queue;

  logic       clk = 1'b0;
  logic       rst, flush, bvld, qrdy;
  logic [7:0] byte_d;
  logic       byte_rdy, q_valid, pfx_pend;
  logic [7:0] lut_op, q_op;
  logic [2:0] lut_page, q_page;
  logic [7:0] lut_sa, q_sa;
  logic [1:0] q_len;
  logic [2:0] q_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign lut_sa = {lut_page, lut_op[4:0]};

  ika87ad_opdec_queue #(.QDEPTH(4), .SA_W(8), .PAGE_W(3)) dut (
    .i_EMUCLK    (clk),
    .i_RESET     (rst),
    .i_FLUSH     (flush),
    .i_BYTE      (byte_d),
    .i_BYTE_VALID(bvld),
    .o_BYTE_READY(byte_rdy),
    .o_LUT_OP    (lut_op),
    .o_LUT_PAGE  (lut_page),
    .i_LUT_SA    (lut_sa),
    .o_Q_VALID   (q_valid),
    .i_Q_READY   (qrdy),
    .o_Q_OP      (q_op),
    .o_Q_PAGE    (q_page),
    .o_Q_SA      (q_sa),
    .o_Q_LEN     (q_len),
    .o_PFX_PEND  (pfx_pend),
    .o_Q_COUNT   (q_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    qrdy = 1'b1;
    tick();
    qrdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] stream [10];
    int idx, npop, cyc;
    logic acc;

    // Reset with a valid byte held
    rst = 1'b1; flush = 1'b0; bvld = 1'b1; byte_d = 8'h12; qrdy = 1'b0;
    repeat (3) tick();
    check_eq("rst_valid", q_valid, 0);
    check_eq("rst_count", q_count, 0);
    check_eq("rst_pfx",   pfx_pend, 0);
    check_eq("rst_op",    q_op, 0);
    check_eq("rst_page",  q_page, 0);
    check_eq("rst_sa",    q_sa, 0);
    check_eq("rst_len",   q_len, 0);
    rst = 1'b0;
    tick();
    bvld = 1'b0;
    check_eq("first_count", q_count, 1);
    check_eq("first_valid", q_valid, 1);
    check_eq("first_op",    q_op, 8'h12);
    check_eq("first_page",  q_page, 0);
    check_eq("first_sa",    q_sa, 8'h12);
    check_eq("first_len",   q_len, 1);
    pop_one();
    check_eq("empty_valid", q_valid, 0);
    check_eq("empty_count", q_count, 0);
    check_eq("empty_hold",  q_op, 8'h12);

    // 48h prefix + 3Ah
    byte_d = 8'h48; bvld = 1'b1;
    tick();
    check_eq("p48_pend",  pfx_pend, 1);
    check_eq("p48_count", q_count, 0);
    byte_d = 8'h3A;
    #1;
    check_eq("p48_lutpage", lut_page, 1);
    check_eq("p48_lutop",   lut_op, 8'h3A);
    tick();
    bvld = 1'b0;
    check_eq("p48_pend_clr", pfx_pend, 0);
    check_eq("p48_count1",   q_count, 1);
    check_eq("p48_op",       q_op, 8'h3A);
    check_eq("p48_page",     q_page, 1);
    check_eq("p48_sa",       q_sa, 8'h3A);
    check_eq("p48_len",      q_len, 2);
    pop_one();

    // 60h then 74h: second prefix value is the opcode
    byte_d = 8'h60; bvld = 1'b1;
    tick();
    byte_d = 8'h74;
    tick();
    bvld = 1'b0;
    check_eq("p60_pend",  pfx_pend, 0);
    check_eq("p60_count", q_count, 1);
    check_eq("p60_op",    q_op, 8'h74);
    check_eq("p60_page",  q_page, 2);
    check_eq("p60_sa",    q_sa, 8'h54);
    check_eq("p60_len",   q_len, 2);
    pop_one();

    // Fill to full with the consumer stalled
    for (int i = 1; i <= 4; i++) begin
      byte_d = 8'(i); bvld = 1'b1;
      tick();
    end
    byte_d = 8'h05;
    #1;
    check_eq("full_rdy",   byte_rdy, 0);
    check_eq("full_count", q_count, 4);
    tick();
    check_eq("full_hold_count", q_count, 4);
    qrdy = 1'b1;
    tick();
    qrdy = 1'b0;
    check_eq("fullpop_count", q_count, 3);
    check_eq("fullpop_head",  q_op, 8'h02);
    #1;
    check_eq("fullpop_rdy", byte_rdy, 1);
    tick();
    bvld = 1'b0;
    check_eq("fifth_count", q_count, 4);
    pop_one();
    check_eq("pre_flush_count", q_count, 3);

    // Prefix pending with 3 entries, then flush with a valid byte
    byte_d = 8'h64; bvld = 1'b1;
    tick();
    check_eq("p64_pend",  pfx_pend, 1);
    check_eq("p64_count", q_count, 3);
    flush = 1'b1; byte_d = 8'h22;
    #1;
    check_eq("flush_rdy", byte_rdy, 0);
    tick();
    flush = 1'b0; bvld = 1'b0;
    check_eq("flush_count", q_count, 0);
    check_eq("flush_pend",  pfx_pend, 0);
    check_eq("flush_valid", q_valid, 0);
    check_eq("flush_hold",  q_op, 8'h03);
    byte_d = 8'h22; bvld = 1'b1;
    tick();
    bvld = 1'b0;
    check_eq("postflush_count", q_count, 1);
    check_eq("postflush_op",    q_op, 8'h22);
    check_eq("postflush_page",  q_page, 0);
    check_eq("postflush_len",   q_len, 1);
    pop_one();

    // Pointer wrap with a toggling consumer
    for (int i = 0; i < 10; i++) stream[i] = 8'h10 + 8'(i);
    idx = 0; npop = 0; cyc = 0;
    while (npop < 10 && cyc < 80) begin
      qrdy = (cyc % 2 == 1);
      bvld = (idx < 10);
      byte_d = (idx < 10) ? stream[idx] : 8'h00;
      #1;
`ifdef IKA87AD_DECQ_BYPASS_EN
      if (q_count == 0 && qrdy && bvld) begin
        check_eq("byp_valid", q_valid, 1);
        check_eq("byp_op",    q_op, stream[idx]);
      end
`else
      if (q_count == 0) check_eq("wrap_empty_valid", q_valid, 0);
`endif
      if (q_valid && qrdy) begin
        check_eq("wrap_op", q_op, stream[npop]);
        npop++;
      end
      acc = bvld && byte_rdy;
      tick();
      if (acc) idx++;
      cyc++;
    end
    bvld = 1'b0; qrdy = 1'b0;
    check_eq("wrap_npop", npop, 10);
    check_eq("wrap_idx",  idx, 10);
    tick();
    check_eq("wrap_end_count", q_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
